// File: rtl/io_port_bank_pkg.sv
// Shared constants and helpers for the CPU I/O port bank.
// Board map: 0,1 display digits, 2 keypad input, 7 LEDs/buzzer.
package io_port_bank_pkg;

  localparam int IO_NCH_MAX = 16;

  localparam logic [IO_NCH_MAX-1:0] IO_OUT_MASK_DEFAULT =
    16'b0000_0000_1000_0011;

  // Lowest bit of channel idx in a packed NCH*W bus.
  function automatic int chan_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/io_chan_fifo.sv
// Single input channel: circular FIFO with sticky overflow flag.
// All outputs depend on registered state only.
module io_chan_fifo
  import io_port_bank_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         ready,
  output logic         avail,
  output logic [W-1:0] head,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign ready   = (cnt != FULL);
  assign avail   = (cnt != '0);
  assign head    = avail ? mem[rd_ptr] : '0;
  assign do_push = push_valid & ready;
  assign do_pop  = pop & avail;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      // ready is registered, so a same-cycle pop cannot absorb this word
      if (push_valid && !ready) ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_port_bank.sv
// CPU I/O port bank: per channel either an output latch
// or an input FIFO, selected by OUT_MASK.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter logic [NCH-1:0] OUT_MASK = NCH'(IO_OUT_MASK_DEFAULT)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [NCH-1:0]   io_ena,
  input  logic [NCH*W-1:0] cpu_wdata,
  output logic [NCH*W-1:0] cpu_rdata,
  output logic [NCH*W-1:0] out,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  output logic [NCH-1:0]   in_avail,
  output logic [NCH-1:0]   ovf
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int LSB = chan_lsb(i, W);

    if (OUT_MASK[i]) begin : g_out
      logic [W-1:0] q;
      logic         unused_in;

      assign unused_in = ^{in_data[LSB +: W], in_valid[i]};

      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)          q <= '0;
        else if (io_ena[i]) q <= cpu_wdata[LSB +: W];
      end

      assign out[LSB +: W]       = q;
      assign cpu_rdata[LSB +: W] = q;
      assign in_ready[i]         = 1'b0;
      assign in_avail[i]         = 1'b0;
      assign ovf[i]              = 1'b0;
    end else begin : g_in
      logic unused_wdata;

      assign unused_wdata = ^cpu_wdata[LSB +: W];

      io_chan_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push_valid (in_valid[i]),
        .push_data  (in_data[LSB +: W]),
        .pop        (io_ena[i]),
        .ready      (in_ready[i]),
        .avail      (in_avail[i]),
        .head       (cpu_rdata[LSB +: W]),
        .ovf        (ovf[i])
      );

      assign out[LSB +: W] = '0;
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with default board map.
// Channels 0,1,7 are latches; 2..6 are FIFOs of depth 4.
module tb_io_port_bank;

  logic        clk;
  logic        rst;
  logic [7:0]  io_ena;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic [63:0] out;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  in_avail;
  logic [7:0]  ovf;

  int checks = 0;
  int errors = 0;

  io_port_bank dut (
    .Clock     (clk),
    .Reset     (rst),
    .io_ena    (io_ena),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .out       (out),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_avail  (in_avail),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd2();
    return cpu_rdata[23:16];
  endfunction

  task automatic push2(input logic [7:0] d);
    in_valid[2] = 1'b1;
    in_data[23:16] = d;
    cycle();
    in_valid[2] = 1'b0;
  endtask

  task automatic pop2();
    io_ena[2] = 1'b1;
    cycle();
    io_ena[2] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    io_ena = '0;
    cpu_wdata = '0;
    in_data = '0;
    in_valid = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("init_ready", 64'(in_ready), 64'h7C);
    chk("init_avail", 64'(in_avail), 64'h00);
    chk("init_out", out, 64'h0);

    // activity, then asynchronous reset between edges
    io_ena[7] = 1'b1;
    cpu_wdata[63:56] = 8'h5A;
    in_valid[2] = 1'b1;
    in_data[23:16] = 8'h77;
    cycle();
    io_ena = '0;
    in_valid = '0;
    chk("pre_rst_out", out, 64'h5A00_0000_0000_0000);
    chk("pre_rst_rd2", 64'(rd2()), 64'h77);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out", out, 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_avail", 64'(in_avail), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h7C);
    chk("rst_rdata", cpu_rdata, 64'h0);
    cycle();
    rst = 1'b0;
    cycle();

    // output latch on channel 7, other slices noisy
    cpu_wdata = 64'hA566_5544_3322_1100;
    io_ena = 8'h80;
    cycle();
    io_ena = '0;
    chk("latch7", out, 64'hA500_0000_0000_0000);
    for (int k = 0; k < 10; k++) begin
      cpu_wdata = {$urandom, $urandom};
      cycle();
    end
    chk("latch7_hold", out, 64'hA500_0000_0000_0000);
    chk("latch7_rdata", cpu_rdata[63:56], 64'hA5);

    cpu_wdata = 64'h0;
    cpu_wdata[15:0] = 16'hC33C;
    io_ena = 8'h03;
    cycle();
    io_ena = '0;
    chk("latch01", out, 64'hA500_0000_0000_C33C);

    // input side of output channels is ignored
    in_valid = 8'h81;
    in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    in_valid = '0;
    in_data = '0;
    chk("iso_out", out, 64'hA500_0000_0000_C33C);
    chk("iso_ready", 64'(in_ready), 64'h7C);
    chk("iso_avail", 64'(in_avail), 64'h00);

    // empty pop
    pop2();
    chk("epop_avail", 64'(in_avail[2]), 64'h0);
    chk("epop_ready", 64'(in_ready[2]), 64'h1);
    chk("epop_rd", 64'(rd2()), 64'h0);
    chk("epop_ovf", 64'(ovf), 64'h0);

    // FIFO order
    push2(8'h11);
    chk("ord_avail", 64'(in_avail[2]), 64'h1);
    chk("ord_rd1", 64'(rd2()), 64'h11);
    push2(8'h22);
    push2(8'h33);
    chk("ord_rd1b", 64'(rd2()), 64'h11);
    pop2();
    chk("ord_rd2", 64'(rd2()), 64'h22);
    pop2();
    chk("ord_rd3", 64'(rd2()), 64'h33);
    pop2();
    chk("ord_empty", 64'(in_avail[2]), 64'h0);
    chk("ord_rd0", 64'(rd2()), 64'h0);

    // overflow with depth 4
    for (int k = 0; k < 4; k++) push2(8'(8'h41 + k));
    chk("ovf_ready", 64'(in_ready[2]), 64'h0);
    chk("ovf_pre", 64'(ovf[2]), 64'h0);
    push2(8'h45);
    chk("ovf_set", 64'(ovf[2]), 64'h1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_pop", 64'(rd2()), 64'(8'h41 + k));
      pop2();
    end
    chk("ovf_empty", 64'(in_avail[2]), 64'h0);
    chk("ovf_sticky", 64'(ovf[2]), 64'h1);

    // simultaneous push/pop at count 2 across wrap
    push2(8'h50);
    push2(8'h51);
    for (int k = 0; k < 8; k++) begin
      in_valid[2] = 1'b1;
      in_data[23:16] = 8'(8'h52 + k);
      io_ena[2] = 1'b1;
      cycle();
      chk("pp_head", 64'(rd2()), 64'(8'h51 + k));
    end
    in_valid[2] = 1'b0;
    io_ena[2] = 1'b0;
    chk("pp_ready", 64'(in_ready[2]), 64'h1);
    pop2();
    chk("pp_last", 64'(rd2()), 64'h59);
    pop2();
    chk("pp_cnt2", 64'(in_avail[2]), 64'h0);

    // push into empty plus pop: only the push lands
    in_valid[2] = 1'b1;
    in_data[23:16] = 8'h6A;
    io_ena[2] = 1'b1;
    cycle();
    in_valid[2] = 1'b0;
    io_ena[2] = 1'b0;
    chk("pe_avail", 64'(in_avail[2]), 64'h1);
    chk("pe_rd", 64'(rd2()), 64'h6A);
    pop2();

    // full plus push plus pop: pop happens, word dropped
    for (int k = 0; k < 4; k++) push2(8'(8'h71 + k));
    in_valid[2] = 1'b1;
    in_data[23:16] = 8'h7F;
    io_ena[2] = 1'b1;
    cycle();
    in_valid[2] = 1'b0;
    io_ena[2] = 1'b0;
    chk("fpp_head", 64'(rd2()), 64'h72);
    chk("fpp_ready", 64'(in_ready[2]), 64'h1);
    pop2();
    pop2();
    chk("fpp_tail", 64'(rd2()), 64'h74);
    pop2();
    chk("fpp_empty", 64'(in_avail[2]), 64'h0);
    chk("fin_out", out, 64'hA500_0000_0000_C33C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised I/O port bank between the CPU's strobed `io_*` ports and board peripherals, generalising the single-channel output latch. Each of `NCH` channels is either an output latch that captures CPU data on its strobe, or an input FIFO that buffers words from a peripheral until the CPU acknowledges them. It sits in the board top level between `CPU` and the display, LED, keypad and buzzer logic.

## Interface
- `NCH`, 8, channel count (1..16)
- `W`, 8, data width per channel
- `DEPTH`, 4, input FIFO depth; power of two, ≥2
- `OUT_MASK`, 8'b1000_0011, bit i = 1 → channel i is an output latch, 0 → input FIFO

- `Clock` in 1, single clock, rising edge
- `Reset` in 1, asynchronous, active-high
- `io_ena` in NCH, CPU strobe per channel, one cycle per access
- `cpu_wdata` in NCH*W, CPU write data; slice i = bits [i*W +: W]
- `cpu_rdata` out NCH*W, slice i = FIFO head (input channel) or latched value (output channel)
- `out` out NCH*W, latched output values; input-channel slices are 0
- `in_data` in NCH*W, peripheral push data
- `in_valid` in NCH, peripheral push request
- `in_ready` out NCH, FIFO not full; constant 0 on output channels
- `in_avail` out NCH, FIFO not empty; constant 0 on output channels
- `ovf` out NCH, sticky overflow flag per input channel

## Operation
- **Output channel:**
  - `io_ena[i]` = 1 → `out[i]` ← `cpu_wdata[i]` at the next edge.
  - Otherwise holds its value.
  - `cpu_rdata[i]` = `out[i]`.
  - `in_*` inputs are ignored.
- **Input channel:** circular buffer with `DEPTH` entries, rd/wr pointers of log2(DEPTH) bits (natural wrap), and a count of log2(DEPTH)+1 bits.
  - Push: `in_valid[i]` & `in_ready[i]`; writes `in_data[i]` at wr pointer, wr pointer +1.
  - Pop: `io_ena[i]` & `in_avail[i]`; rd pointer +1.
  - `cpu_rdata[i]` = entry at rd pointer when non-empty, else 0.
  - `cpu_wdata[i]` is ignored.
- **Boundaries:**
  - Push while full: data dropped, pointers unchanged, `ovf[i]` set. A pop in the same cycle does not rescue it, because `in_ready` is the registered-state "not full".
  - Pop while empty: ignored, no error.
  - Push and pop in the same cycle, non-empty and not full: both happen, count unchanged.
  - Push into an empty FIFO plus pop in the same cycle: only the push takes effect (the pop is gated by `in_avail`).
  - `ovf[i]` clears only on `Reset`.
- **Reset (any time, mid-transfer included):**
  - Pointers and counts → 0; `out` → 0; `ovf` → 0.
  - `in_ready` → 1 on input channels.
  - `in_avail` → 0; `cpu_rdata` → 0.
  - FIFO storage contents are don't-care.

## Timing
- Output latch: one-cycle latency from strobe to `out`.
- Input push to `in_avail`/`cpu_rdata`: visible one cycle after the push edge.
- Pop: `cpu_rdata` advances to the next entry one cycle after the strobe edge.
- `in_ready`, `in_avail` and `cpu_rdata` are functions of registered state only; there is no combinational path from any input to any output.
- Sustained throughput: one push and one pop per cycle per channel.
- Reset is asserted asynchronously and released synchronously by the existing reset recovery upstream.

## Structure
- Shared package:
  - `IO_NCH_MAX` = 16
  - channel-slice helper function (index → bit range)
  - default `OUT_MASK` constant for the board map: 0,1 = display digits, 7 = LEDs/buzzer, 2 = keypad input
- Sub-module `io_chan_fifo` (params `W`, `DEPTH`): one input FIFO with push/pop/ready/avail/ovf.
- Top level: `generate` loop choosing `io_chan_fifo` or a W-bit latch per channel from `OUT_MASK[i]`.

## Test plan
- **Reset state:** reset asserted mid-run → all `out` = 0, `ovf` = 0, `in_avail` = 0, `in_ready[2]` = 1, `cpu_rdata` = 0, all asynchronously before the next edge.
- **Output latch:** `io_ena[7]` pulse with slice 7 = 8'hA5 → `out[7]` = 8'hA5 next cycle; holds through 10 idle cycles; other slices unchanged.
- **FIFO order:** push 8'h11, 8'h22, 8'h33 on channel 2 → `in_avail[2]` = 1, `cpu_rdata[2]` = 8'h11. Three pops → 8'h22, then 8'h33, then `in_avail` = 0 and `cpu_rdata` = 0.
- **Overflow:** push 5 words with `DEPTH` = 4 → `in_ready[2]` = 0 after the 4th push, 5th word dropped, `ovf[2]` = 1. Four pops return words 1..4; `ovf[2]` stays 1.
- **Simultaneous push/pop:** FIFO holds 2 words; push and pop in the same cycle for 8 cycles → count remains 2 and words come out in push order across pointer wrap.
- **Empty pop and mode isolation:**
  - Strobe `io_ena[2]` on an empty FIFO → no state change.
  - `in_valid[0]` on output channel 0 → no effect on `out[0]`.
